// File: rtl/fetch_execute_queue.sv
// fetch_execute_queue: DEPTH-entry handshaked FIFO between fetch and execute.
// Each entry carries {pc, instr, prediction}; pc4 is rebuilt on the way out.
// A redirect flush empties the queue in one cycle; BYPASS=1 lets an enqueue
// into an empty queue appear on the dequeue side in the same cycle.
module fetch_execute_queue #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [WORD_W-1:0]          enq_pc,
    input  logic [WORD_W-1:0]          enq_instr,
    input  logic [WORD_W-1:0]          enq_prediction,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [WORD_W-1:0]          deq_pc,
    output logic [WORD_W-1:0]          deq_instr,
    output logic [WORD_W-1:0]          deq_prediction,
    output logic [WORD_W-1:0]          deq_pc4,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] prediction;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             empty;
    logic             bypass_hit;
    logic             bypass_take;
    logic             enq_fire;
    logic             deq_fire;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Ready depends only on occupancy and reset, never on deq_ready.
    assign enq_ready = !full && !RST;

    // Bypass applies only to an empty queue with no redirect or reset pending.
    assign bypass_hit  = BYPASS && empty && enq_valid && !flush && !RST;
    // A bypassed item taken the same cycle never touches storage.
    assign bypass_take = bypass_hit && deq_ready;

    assign deq_valid = bypass_hit || (!empty && !flush);

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;
    assign wr_en    = enq_fire && !bypass_take;
    assign rd_en    = deq_fire && !bypass_take;

    // Head-side output mux: storage head, or the incoming entry when bypassing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        deq_pc         = head.pc;
        deq_instr      = head.instr;
        deq_prediction = head.prediction;
        if (bypass_hit) begin
            deq_pc         = enq_pc;
            deq_instr      = enq_instr;
            deq_prediction = enq_prediction;
        end
    end

    // Carry out of the top bit is simply dropped.
    assign deq_pc4 = deq_pc + WORD_W'(4);

    // Pointer, occupancy and storage update; reset beats flush beats handshakes.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset here because the head entry is directly observable on deq_*.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{pc: enq_pc, instr: enq_instr, prediction: enq_prediction};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

endmodule

// File: tb/tb_fetch_execute_queue.sv
// Directed bench for fetch_execute_queue: a BYPASS=0 instance exercised for
// fill/drain, wrap, flush, pc4 wrap and mid-stream reset, plus a BYPASS=1
// instance for the empty-queue bypass path. A queue of expected pcs is the model.
module tb_fetch_execute_queue;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RST;

    logic         enq_valid, enq_ready, deq_valid, deq_ready, flush;
    logic [W-1:0] enq_pc, enq_instr, enq_prediction;
    logic [W-1:0] deq_pc, deq_instr, deq_prediction, deq_pc4;
    logic [2:0]   count;

    logic         bp_enq_valid, bp_enq_ready, bp_deq_valid, bp_deq_ready, bp_flush;
    logic [W-1:0] bp_enq_pc, bp_enq_instr, bp_enq_prediction;
    logic [W-1:0] bp_deq_pc, bp_deq_instr, bp_deq_prediction, bp_deq_pc4;
    logic [2:0]   bp_count;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] model_q[$];

    always #5 CLK = ~CLK;

    fetch_execute_queue #(.WORD_W(W), .DEPTH(DEPTH), .BYPASS(1'b0)) dut (
        .CLK(CLK), .RST(RST),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_instr(enq_instr), .enq_prediction(enq_prediction),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_instr(deq_instr), .deq_prediction(deq_prediction),
        .deq_pc4(deq_pc4), .flush(flush), .count(count)
    );

    fetch_execute_queue #(.WORD_W(W), .DEPTH(DEPTH), .BYPASS(1'b1)) dut_bp (
        .CLK(CLK), .RST(RST),
        .enq_valid(bp_enq_valid), .enq_ready(bp_enq_ready),
        .enq_pc(bp_enq_pc), .enq_instr(bp_enq_instr), .enq_prediction(bp_enq_prediction),
        .deq_valid(bp_deq_valid), .deq_ready(bp_deq_ready),
        .deq_pc(bp_deq_pc), .deq_instr(bp_deq_instr), .deq_prediction(bp_deq_prediction),
        .deq_pc4(bp_deq_pc4), .flush(bp_flush), .count(bp_count)
    );

    function automatic logic [W-1:0] mk_instr(input logic [W-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [W-1:0] mk_pred(input logic [W-1:0] pc);
        return pc + 32'd8;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the BYPASS=0 instance: drive, check against the model, clock, update model.
    task automatic cycle(input logic ev, input logic [W-1:0] pc, input logic dr);
        int  sz;
        logic acc, pop;
        enq_valid      = ev;
        enq_pc         = pc;
        enq_instr      = mk_instr(pc);
        enq_prediction = mk_pred(pc);
        deq_ready      = dr;
        flush          = 1'b0;
        #1;
        sz = model_q.size();
        check("count", 32'(count), 32'(sz));
        check("enq_ready", 32'(enq_ready), (sz < DEPTH) ? 32'd1 : 32'd0);
        check("deq_valid", 32'(deq_valid), (sz != 0) ? 32'd1 : 32'd0);
        if (sz != 0) begin
            check("deq_pc", deq_pc, model_q[0]);
            check("deq_instr", deq_instr, mk_instr(model_q[0]));
            check("deq_prediction", deq_prediction, mk_pred(model_q[0]));
            check("deq_pc4", deq_pc4, model_q[0] + 32'd4);
        end
        acc = ev && (sz < DEPTH);
        pop = dr && (sz != 0);
        @(posedge CLK);
        #1;
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back(pc);
    endtask

    initial begin
        RST = 1'b1;
        enq_valid = 0; deq_ready = 0; flush = 0;
        enq_pc = '0; enq_instr = '0; enq_prediction = '0;
        bp_enq_valid = 0; bp_deq_ready = 0; bp_flush = 0;
        bp_enq_pc = '0; bp_enq_instr = '0; bp_enq_prediction = '0;

        // Reset state
        @(posedge CLK);
        #1;
        check("rst_enq_ready_high", 32'(enq_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_deq_pc", deq_pc, 32'd0);
        check("rst_deq_instr", deq_instr, 32'd0);
        check("rst_deq_prediction", deq_prediction, 32'd0);
        check("rst_deq_pc4", deq_pc4, 32'd4);
        RST = 1'b0;
        #1;
        check("rst_enq_ready_after", 32'(enq_ready), 32'd1);

        // Fill to DEPTH with no dequeue, then a refused 5th item, then drain in order
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 1'b0);
        cycle(1'b1, 32'h110, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);

        // Pre-fill two, then stream twelve with simultaneous enq/deq across pointer wrap
        cycle(1'b1, 32'h400, 1'b0);
        cycle(1'b1, 32'h404, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 32'h408 + 32'(4 * i), 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);

        // Flush colliding with enqueue and dequeue at count 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(4 * i), 1'b0);
        enq_valid = 1'b1; enq_pc = 32'h200; enq_instr = mk_instr(32'h200);
        enq_prediction = mk_pred(32'h200); deq_ready = 1'b1; flush = 1'b1;
        #1;
        check("flush_deq_valid", 32'(deq_valid), 32'd0);
        @(posedge CLK);
        #1;
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        model_q.delete();
        #1;
        check("flush_count_after", 32'(count), 32'd0);
        check("flush_enq_ready_after", 32'(enq_ready), 32'd1);
        check("flush_deq_valid_after", 32'(deq_valid), 32'd0);
        cycle(1'b1, 32'h600, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);

        // pc4 wrap-around
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
        #1;
        check("pc4_wrap", deq_pc4, 32'h0000_0000);
        cycle(1'b0, 32'h0, 1'b1);

        // Reset pulse mid-stream with an enqueue attempt
        cycle(1'b1, 32'h700, 1'b0);
        cycle(1'b1, 32'h704, 1'b0);
        RST = 1'b1; enq_valid = 1'b1; enq_pc = 32'h708; deq_ready = 1'b0;
        #1;
        check("midrst_enq_ready", 32'(enq_ready), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0; enq_valid = 1'b0;
        model_q.delete();
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_deq_valid", 32'(deq_valid), 32'd0);
        check("midrst_deq_pc", deq_pc, 32'd0);
        check("midrst_deq_pc4", deq_pc4, 32'd4);

        // BYPASS=1: empty queue, consumed in the same cycle
        bp_enq_valid = 1'b1; bp_enq_pc = 32'h300; bp_enq_instr = mk_instr(32'h300);
        bp_enq_prediction = mk_pred(32'h300); bp_deq_ready = 1'b1;
        #1;
        check("bp_same_deq_valid", 32'(bp_deq_valid), 32'd1);
        check("bp_same_deq_pc", bp_deq_pc, 32'h300);
        check("bp_same_deq_instr", bp_deq_instr, mk_instr(32'h300));
        check("bp_same_count", 32'(bp_count), 32'd0);
        @(posedge CLK);
        #1;
        bp_enq_valid = 1'b0; bp_deq_ready = 1'b0;
        #1;
        check("bp_taken_count", 32'(bp_count), 32'd0);
        check("bp_taken_deq_valid", 32'(bp_deq_valid), 32'd0);

        // BYPASS=1: empty queue, not consumed, so it must be stored and held
        bp_enq_valid = 1'b1; bp_deq_ready = 1'b0;
        #1;
        check("bp_hold_same_valid", 32'(bp_deq_valid), 32'd1);
        check("bp_hold_same_pc", bp_deq_pc, 32'h300);
        @(posedge CLK);
        #1;
        bp_enq_valid = 1'b0;
        #1;
        check("bp_hold_count", 32'(bp_count), 32'd1);
        check("bp_hold_deq_valid", 32'(bp_deq_valid), 32'd1);
        check("bp_hold_deq_pc", bp_deq_pc, 32'h300);
        check("bp_hold_deq_prediction", bp_deq_prediction, mk_pred(32'h300));
        @(posedge CLK);
        #1;
        check("bp_hold_stable_pc", bp_deq_pc, 32'h300);
        bp_deq_ready = 1'b1;
        @(posedge CLK);
        #1;
        bp_deq_ready = 1'b0;
        #1;
        check("bp_drain_count", 32'(bp_count), 32'd0);
        check("bp_drain_deq_valid", 32'(bp_deq_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_execute_queue.md
# fetch_execute_queue

Parametrised, handshaked instruction queue between the fetch and execute pipeline stages. It replaces the bare fetch/execute signal bundle with a DEPTH-entry FIFO carrying {pc, instr, prediction} per fetched instruction and a valid/ready handshake on both sides. On a branch/jump redirect it supports a single-cycle flush, and an optional empty-queue bypass. pc4 is derived on the execute side rather than stored.

## Interface
- WORD_W, 32: width of pc, instr, prediction, pc4.
- DEPTH, 4: number of entries; power of two, ≥ 2.
- BYPASS, 0: 1 = an enqueue into an empty queue is visible on deq_* in the same cycle.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- enq_valid  in  1  fetch presents an instruction.
- enq_ready  out  1  queue can accept; = !full && !RST.
- enq_pc, enq_instr, enq_prediction  in  WORD_W each  fetched pc, instruction word, predicted next pc.
- deq_valid  out  1  head entry valid for execute.
- deq_ready  in  1  execute consumes head this cycle.
- deq_pc, deq_instr, deq_prediction  out  WORD_W each  head entry fields.
- deq_pc4  out  WORD_W  deq_pc + 4, modulo 2^WORD_W.
- flush  in  1  redirect from execute (brj_addr taken / mispredict); discard all entries.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH × {pc, instr, prediction} registers, head pointer rd_ptr and tail pointer wr_ptr, each $clog2(DEPTH) bits, plus the occupancy counter count.
- Enqueue fires when enq_valid && enq_ready && !flush. Entry is written at wr_ptr, and wr_ptr increments, wrapping DEPTH-1 → 0.
- Dequeue fires when deq_valid && deq_ready && !flush. rd_ptr increments with the same wrap.
- count_next = count + enq_fire − deq_fire. A simultaneous enq and deq leaves count unchanged.
- enq_ready does not depend on deq_ready, so there is no combinational ready path. At full, enq_ready = 0 even if deq_ready = 1.
- enq_valid while enq_ready = 0: the instruction is not accepted. Fetch must hold it.
- Flush has priority over everything:
  - rd_ptr, wr_ptr and count go to 0 next edge.
  - Same-cycle enq and deq are discarded.
  - deq_valid is forced 0 in the flush cycle.
- BYPASS = 0: deq_valid = (count != 0) && !flush, and deq_* come from the entry at rd_ptr.
- BYPASS = 1, count == 0, enq_valid = 1, no flush:
  - deq_valid = 1 and deq_* = enq_* combinationally.
  - If deq_ready = 1 in that cycle, the item is consumed and not stored, so count stays 0.
  - Otherwise the item is stored normally.
- deq_pc4 is combinational from deq_pc. Carry out of bit WORD_W-1 is dropped.

## Timing
- Reset, at the edge where RST = 1: pointers = 0, count = 0, all storage entries = 0.
  - Resulting outputs: deq_valid = 0, deq_pc = deq_instr = deq_prediction = 0, deq_pc4 = 4, count = 0.
  - enq_ready = 0 while RST is high, and 1 in the first cycle after RST falls.
- RST asserted mid-operation: contents are lost at that edge. Any handshake in the RST-high cycle is ignored.
- Latency with BYPASS = 0: an item enqueued at edge N is on deq_* with deq_valid = 1 in cycle N+1.
- Latency with BYPASS = 1 and the queue empty: 0 cycles.
- Throughput: one enqueue and one dequeue per cycle sustained when 0 < count < DEPTH.
- After a flush at edge N: count = 0 and enq_ready = 1 in cycle N+1. An enqueue in cycle N+1 is the first post-redirect instruction.
- Outputs are stable from the head entry while deq_valid = 1 && deq_ready = 0.

## Test plan
- Fill/drain, DEPTH = 4, BYPASS = 0:
  - Stimulus: enqueue pcs 0x100, 0x104, 0x108, 0x10C with deq_ready = 0.
  - Required: count = 4 and enq_ready = 0; a 5th enq_valid is not accepted.
  - Then deq_ready = 1: pcs emerge in order, deq_pc4 = 0x104…0x110, and count returns to 0.
- Wrap plus simultaneous enq/deq:
  - Stimulus: stream 12 items with enq_valid = deq_ready = 1 continuously, after pre-filling 2.
  - Required: count holds at 2, with no loss or reordering across pointer wrap.
- Flush collision:
  - Stimulus: with count = 3, assert flush together with enq_valid = 1 (pc 0x200) and deq_ready = 1.
  - Required: deq_valid = 0 that cycle, count = 0 next cycle, and 0x200 never appears.
- pc4 wrap:
  - Stimulus: enqueue pc 0xFFFF_FFFC.
  - Required: deq_pc4 = 0x0000_0000.
- Reset mid-stream:
  - Stimulus: with count = 2, pulse RST for 1 cycle while enq_valid = 1.
  - Required: enq_ready = 0 during RST; then count = 0, deq_valid = 0, deq_pc = 0, deq_pc4 = 4.
- BYPASS = 1, empty queue:
  - Stimulus: enq_valid = 1 with pc 0x300 and deq_ready = 1.
  - Required: deq_valid = 1 and deq_pc = 0x300 in the same cycle, with count staying 0.
  - With deq_ready = 0 instead: count = 1 next cycle and deq_pc = 0x300 held.
